// File: rtl/twos_complement_adder_16bit.sv
// ----------------------------------------------------------------------------
// twos_complement_adder_16bit
//
// Purpose:
//   16-bit two's-complement adder/subtractor for the single-cycle RISC ALU.
//   Supports ADD, ADC (add with carry), SUB and SBB (subtract with borrow).
//   The sum is built from a 16-cell ripple chain of full adders. The result,
//   the carry out of bit 15 and the carry into bit 15 are registered, so the
//   flag logic can derive both carry and signed overflow.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   asynchronous, active-high reset
//   A       in  16   minuend / first addend
//   B       in  16   subtrahend / second addend
//   SBB     in   1   subtract-with-borrow mode strobe
//   SUB     in   1   subtract mode strobe
//   C       in   1   incoming carry flag (ADC carry, SBB borrow select)
//   ADC     in   1   add-with-carry mode strobe
//   Y       out 16   registered result
//   Cout    out  1   registered carry out of bit 15
//   Cout_1  out  1   registered carry out of bit 14 (carry into bit 15)
//   OVF     out  1   registered signed overflow (only with TWOS_ADDER_OVF_EN)
//
// Configuration:
//   TWOS_ADDER_OVF_EN  when defined, adds the registered OVF output.
//
// Mode priority when several strobes are high: SUB > SBB > ADC > ADD.
// Latency: one clock.
// ----------------------------------------------------------------------------
module twos_complement_adder_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        SBB,
  input  logic        SUB,
  input  logic        C,
  input  logic        ADC,
  output logic [15:0] Y,
  output logic        Cout,
  output logic        Cout_1
`ifdef TWOS_ADDER_OVF_EN
  ,
  output logic        OVF
`endif
);

  logic        invert_b;
  logic        cin;
  logic [15:0] bx;
  logic [16:0] carry;
  logic [15:0] sum;

  logic [15:0] y_reg;
  logic        cout_reg;
  logic        cout_1_reg;

  // Mode decode. Both subtract modes invert B; the carry-in follows the
  // SUB > SBB > ADC > ADD priority. C only matters for ADC and SBB.
  always_comb begin
    invert_b = SUB | SBB;
    cin      = 1'b0;
    if (SUB) begin
      cin = 1'b1;
    end else if (SBB) begin
      cin = ~C;
    end else if (ADC) begin
      cin = C;
    end
  end

  assign bx       = invert_b ? ~B : B;
  assign carry[0] = cin;

  // Ripple-carry chain: one full adder per bit.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fa
      assign sum[gi]      = A[gi] ^ bx[gi] ^ carry[gi];
      assign carry[gi+1]  = (A[gi] & bx[gi]) | (A[gi] & carry[gi]) |
                            (bx[gi] & carry[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg      <= 16'h0000;
      cout_reg   <= 1'b0;
      cout_1_reg <= 1'b0;
    end else begin
      y_reg      <= sum;
      cout_reg   <= carry[16];
      cout_1_reg <= carry[15];
    end
  end

  assign Y      = y_reg;
  assign Cout   = cout_reg;
  assign Cout_1 = cout_1_reg;

`ifdef TWOS_ADDER_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= carry[16] ^ carry[15];
    end
  end

  assign OVF = ovf_reg;
`endif

endmodule

// File: tb/tb_twos_complement_adder_16bit.sv
// ----------------------------------------------------------------------------
// Testbench for twos_complement_adder_16bit.
// Directed steps in one initial block; expected results are pushed to a
// scoreboard queue when stimulus is driven and popped one edge later.
// ----------------------------------------------------------------------------
module tb_twos_complement_adder_16bit;

  logic        clk;
  logic        rst;
  logic [15:0] A;
  logic [15:0] B;
  logic        SBB;
  logic        SUB;
  logic        C;
  logic        ADC;
  logic [15:0] Y;
  logic        Cout;
  logic        Cout_1;
`ifdef TWOS_ADDER_OVF_EN
  logic        OVF;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_y_q[$];
  logic        exp_co_q[$];
  logic        exp_c1_q[$];
  string       tag_q[$];

  twos_complement_adder_16bit dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .SBB    (SBB),
    .SUB    (SUB),
    .C      (C),
    .ADC    (ADC),
    .Y      (Y),
    .Cout   (Cout),
    .Cout_1 (Cout_1)
`ifdef TWOS_ADDER_OVF_EN
    ,
    .OVF    (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  // Drive one operation and push its expected outcome.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic sbb, input logic adc,
                       input logic c, input logic [15:0] ey,
                       input logic eco, input logic ec1, input string tag);
    A   = a;
    B   = b;
    SUB = sub;
    SBB = sbb;
    ADC = adc;
    C   = c;
    exp_y_q.push_back(ey);
    exp_co_q.push_back(eco);
    exp_c1_q.push_back(ec1);
    tag_q.push_back(tag);
  endtask

  // Advance exactly one edge and compare against the oldest expectation.
  task automatic step();
    logic [15:0] ey;
    logic        eco;
    logic        ec1;
    string       tag;
    @(posedge clk);
    #1;
    if (exp_y_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue required pending entry");
    end else begin
      ey  = exp_y_q.pop_front();
      eco = exp_co_q.pop_front();
      ec1 = exp_c1_q.pop_front();
      tag = tag_q.pop_front();
      chk({tag, ".Y"}, Y, ey);
      chk({tag, ".Cout"}, {15'd0, Cout}, {15'd0, eco});
      chk({tag, ".Cout_1"}, {15'd0, Cout_1}, {15'd0, ec1});
`ifdef TWOS_ADDER_OVF_EN
      chk({tag, ".OVF"}, {15'd0, OVF}, {15'd0, eco ^ ec1});
`endif
      $display("txn %s: A=%h B=%h -> Y=%h Cout=%b Cout_1=%b", tag, A, B, Y, Cout, Cout_1);
    end
  endtask

  // Behavioural reference: integer arithmetic, priority SUB > SBB > ADC > ADD.
  task automatic model(input logic [15:0] a, input logic [15:0] b,
                       input logic sub, input logic sbb, input logic adc,
                       input logic c, output logic [15:0] ey,
                       output logic eco, output logic ec1);
    logic [15:0] bo;
    logic [16:0] full;
    logic [15:0] low;
    int          ci;
    if (sub) begin
      bo = ~b; ci = 1;
    end else if (sbb) begin
      bo = ~b; ci = c ? 0 : 1;
    end else if (adc) begin
      bo = b; ci = c ? 1 : 0;
    end else begin
      bo = b; ci = 0;
    end
    full = {1'b0, a} + {1'b0, bo} + 17'(ci);
    low  = {1'b0, a[14:0]} + {1'b0, bo[14:0]} + 16'(ci);
    ey   = full[15:0];
    eco  = full[16];
    ec1  = low[15];
  endtask

  initial begin
    logic [15:0] ra, rb, ey;
    logic        rsub, rsbb, radc, rc, eco, ec1;

    rst = 1'b1;
    A = 16'h0; B = 16'h0; SUB = 0; SBB = 0; ADC = 0; C = 0;

    // Reset state
    #1;
    chk("reset0.Y", Y, 16'h0000);
    chk("reset0.Cout", {15'd0, Cout}, 16'h0000);
    chk("reset0.Cout_1", {15'd0, Cout_1}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // SBB
    issue(16'h4567, 16'h1234, 0, 1, 0, 0, 16'h3333, 1, 1, "sbb_c0");
    step();
    issue(16'h4567, 16'h1234, 0, 1, 0, 1, 16'h3332, 1, 1, "sbb_c1");
    step();
    // SUB, C ignored
    issue(16'h4567, 16'h1234, 1, 0, 0, 0, 16'h3333, 1, 1, "sub");
    step();
    issue(16'h4567, 16'h1234, 1, 0, 0, 1, 16'h3333, 1, 1, "sub_c_ign");
    step();
    issue(16'h0000, 16'h0001, 1, 0, 0, 0, 16'hFFFF, 0, 0, "sub_borrow");
    step();
    // ADC
    issue(16'h4567, 16'h1234, 0, 0, 1, 0, 16'h579B, 0, 0, "adc_c0");
    step();
    issue(16'h4567, 16'h1234, 0, 0, 1, 1, 16'h579C, 0, 0, "adc_c1");
    step();
    // ADD overflow and wrap, C ignored
    issue(16'h7FFF, 16'h0001, 0, 0, 0, 1, 16'h8000, 0, 1, "add_ovf");
    step();
    issue(16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 1, "add_wrap");
    step();
    // Priority
    issue(16'h4567, 16'h1234, 1, 1, 1, 1, 16'h3333, 1, 1, "prio_sub");
    step();
    issue(16'h4567, 16'h1234, 0, 1, 1, 1, 16'h3332, 1, 1, "prio_sbb");
    step();

    // Back-to-back pipelined operations from the model
    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rsub = 1'($urandom); rsbb = 1'($urandom);
      radc = 1'($urandom); rc = 1'($urandom);
      if (i < 4) begin
        ra = 16'h8000 >> i; rb = 16'h8000;
      end
      model(ra, rb, rsub, rsbb, radc, rc, ey, eco, ec1);
      issue(ra, rb, rsub, rsbb, radc, rc, ey, eco, ec1, $sformatf("rand%0d", i));
      step();
    end

    // Make the registered state nonzero before the reset check
    issue(16'h4567, 16'h1234, 0, 0, 1, 1, 16'h579C, 0, 0, "pre_rst");
    step();

    // Asynchronous reset between edges, with an operation in flight
    A = 16'hFFFF; B = 16'h0001; SUB = 0; SBB = 0; ADC = 0; C = 0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.Y", Y, 16'h0000);
    chk("async_rst.Cout", {15'd0, Cout}, 16'h0000);
    chk("async_rst.Cout_1", {15'd0, Cout_1}, 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_held.Y", Y, 16'h0000);
    chk("rst_held.Cout", {15'd0, Cout}, 16'h0000);
    rst = 1'b0;
    // First valid result one edge after release
    issue(16'hFFFF, 16'h0001, 0, 0, 0, 0, 16'h0000, 1, 1, "post_rst");
    step();

    chk("sb_drained", 16'(exp_y_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/twos_complement_adder_16bit.md
# twos_complement_adder_16bit

16-bit two's-complement adder/subtractor with carry/borrow-in modes for the single-cycle RISC datapath ALU. Selects ADD, ADC (add with carry), SUB or SBB (subtract with borrow) from one-hot-style mode strobes. Produces the 16-bit result, the MSB carry-out and the carry into the MSB, so the flag logic can derive carry and signed overflow. Outputs are registered.

## Interface
- Clocking: one clock; reset is asynchronous and active-high.
- No parameters; width fixed at 16.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- A  input  16  minuend / first addend.
- B  input  16  subtrahend / second addend.
- SBB  input  1  subtract-with-borrow mode strobe.
- SUB  input  1  subtract mode strobe.
- C  input  1  incoming carry flag (carry for ADC, borrow-select for SBB).
- ADC  input  1  add-with-carry mode strobe.
- Y  output  16  registered result.
- Cout  output  1  registered carry out of bit 15.
- Cout_1  output  1  registered carry out of bit 14 (carry into bit 15).

## Operation
- Mode priority when several strobes are high: SUB > SBB > ADC > ADD (all low = ADD).
- Operand Bx = ~B for SUB/SBB, B otherwise; carry-in cin:
  - ADD: cin = 0 → Y = A + B.
  - ADC: cin = C → Y = A + B + C.
  - SUB: cin = 1 → Y = A + ~B + 1 = A − B.
  - SBB: cin = ~C → Y = A + ~B + ~C = A − B − C.
- Sum formed as a 16-cell ripple-carry chain of full adders; c[i+1] = majority(A[i], Bx[i], c[i]), c[0] = cin.
- Cout = c[16]; Cout_1 = c[15]. For subtract modes Cout = 1 means no borrow.
- Signed overflow is Cout ^ Cout_1 (computed by the flag logic, or internally per Configuration).
- All arithmetic modulo 2^16; no saturation.
- C is ignored in ADD and SUB.

## Timing
- Combinational adder feeds an output register; latency 1 clock: inputs sampled at rising edge n appear on Y/Cout/Cout_1 after edge n.
- Reset: Y = 16'h0000, Cout = 0, Cout_1 = 0, asserted immediately on rst rising, independent of clk.
- Reset mid-operation discards the in-flight result; first valid result appears one edge after rst deasserts.
- No handshake; a new operation is accepted every cycle.
- Mode strobes changing between edges have no effect until the next edge.

## Configuration
- TWOS_ADDER_OVF_EN: when defined, adds output OVF (1 bit, registered, reset 0) = Cout ^ Cout_1 of the same operation, aligned with Y. When undefined, the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset: assert rst with A=16'hFFFF, B=16'h0001 → Y=16'h0000, Cout=0, Cout_1=0 while rst high, without a clock edge.
- SBB, A=16'h4567, B=16'h1234, C=0 → Y=16'h3333, Cout=1, Cout_1=1; with C=1 → Y=16'h3332, Cout=1, Cout_1=1.
- SUB, A=16'h4567, B=16'h1234, C=0 → Y=16'h3333, Cout=1, Cout_1=1; A=16'h0000, B=16'h0001 → Y=16'hFFFF, Cout=0 (borrow).
- ADC, A=16'h4567, B=16'h1234, C=0 → Y=16'h579B, Cout=0, Cout_1=0; C=1 → Y=16'h579C.
- ADD overflow/wrap: A=16'h7FFF, B=16'h0001 → Y=16'h8000, Cout=0, Cout_1=1 (OVF=1 if enabled); A=16'hFFFF, B=16'h0001 → Y=16'h0000, Cout=1, Cout_1=1.
- Priority: SUB=1, SBB=1, ADC=1, C=1, A=16'h4567, B=16'h1234 → SUB result Y=16'h3333; each result appears exactly one edge after the inputs are applied.
